// File: rtl/div_sequencer_pkg.sv
// Shared types, constants and small helpers for the iterative divider.
package div_sequencer_pkg;

  localparam int XLEN               = 32;
  localparam int COUNT_SIZE_DIVISOR = 5;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9,
    ALU_MUL  = 5'd10,
    ALU_DIV  = 5'd14,
    ALU_DIVU = 5'd15,
    ALU_REM  = 5'd16,
    ALU_REMU = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam logic [XLEN-1:0] DIV_SIGNED_OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [XLEN-1:0] DIV_BY_ZERO_QUOTIENT    = '1;

  // True for the four operations handled by the divider.
  function automatic logic is_div_op(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  // True for the signed variants.
  function automatic logic is_signed_op(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  // True when the quotient (not the remainder) is returned.
  function automatic logic is_quot_op(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  // Two's complement negate when neg is set; |0x80000000| stays 0x80000000.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bundle between the EX stage and the divider.
interface div_sequencer_if import div_sequencer_pkg::*; ();
  logic            start;
  alu_op_e         alu_op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, alu_op, operand_a, operand_b, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, alu_op, operand_a, operand_b, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/div_sequencer_step.sv
// One restoring-division iteration: shift {rem,quo} left and try to subtract.
module div_sequencer_step import div_sequencer_pkg::*; (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);
  // rem < divisor always holds, so the difference fits in XLEN+1 signed bits.
  logic [XLEN:0] w_trial;

  // Trial subtraction and restore decision.
  always_comb begin
    w_trial = {i_rem, i_quo[XLEN-1]} - {1'b0, i_divisor};
    if (w_trial[XLEN] == 1'b0) begin
      o_rem = w_trial[XLEN-1:0];
      o_quo = {i_quo[XLEN-2:0], 1'b1};
    end else begin
      o_rem = {i_rem[XLEN-2:0], i_quo[XLEN-1]};
      o_quo = {i_quo[XLEN-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider with its control FSM (DIV/DIVU/REM/REMU).
module div_sequencer import div_sequencer_pkg::*; (
  input  logic            i_clk,
  input  logic            i_rst_n,
  div_sequencer_if.slave  bus
);
  div_state_e                    r_state;
  div_state_e                    w_state_next;
  logic [COUNT_SIZE_DIVISOR-1:0] r_count;
  logic [XLEN-1:0]               r_rem;
  logic [XLEN-1:0]               r_quo;
  logic [XLEN-1:0]               r_divisor;
  logic [XLEN-1:0]               r_result;
  alu_op_e                       r_op;
  logic                          r_neg_q;
  logic                          r_neg_r;

  logic            w_accept;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN-1:0] w_fix_res;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_quo_next;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_sgn;

  div_sequencer_step u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_quo     (w_quo_next)
  );

  // Decode the incoming request: acceptance, special cases and their results.
  always_comb begin
    w_sgn    = is_signed_op(bus.alu_op);
    w_accept = bus.start & is_div_op(bus.alu_op);
    w_b_zero = (bus.operand_b == 32'h0000_0000);
    w_ovf    = w_sgn & (bus.operand_a == DIV_SIGNED_OVF_DIVIDEND) &
               (bus.operand_b == 32'hFFFF_FFFF);
    w_special = w_b_zero | w_ovf;
    if (is_quot_op(bus.alu_op)) begin
      w_special_res = w_b_zero ? DIV_BY_ZERO_QUOTIENT : DIV_SIGNED_OVF_DIVIDEND;
    end else begin
      w_special_res = w_b_zero ? bus.operand_a : 32'h0000_0000;
    end
    w_fix_res = is_quot_op(r_op) ? cond_neg(r_quo, r_neg_q) : cond_neg(r_rem, r_neg_r);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush wins over everything including start.
  always_comb begin
    w_state_next = r_state;
    if (bus.flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_state_next = w_special ? DONE : CALC;
          end else begin
            w_state_next = IDLE;
          end
        end
        CALC: begin
          if (r_count == 5'd0) begin
            w_state_next = FIX;
          end else begin
            w_state_next = CALC;
          end
        end
        FIX:     w_state_next = DONE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Datapath registers: operand capture, iteration and result write-back.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_op      <= ALU_ADD;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else if (!bus.flush) begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op <= bus.alu_op;
            if (w_special) begin
              r_result <= w_special_res;
            end else begin
              r_rem     <= '0;
              r_quo     <= cond_neg(bus.operand_a, w_sgn & bus.operand_a[XLEN-1]);
              r_divisor <= cond_neg(bus.operand_b, w_sgn & bus.operand_b[XLEN-1]);
              r_neg_q   <= w_sgn & (bus.operand_a[XLEN-1] ^ bus.operand_b[XLEN-1]);
              r_neg_r   <= w_sgn & bus.operand_a[XLEN-1];
              r_count   <= 5'd31;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (r_count != 5'd0) begin
            r_count <= r_count - 5'd1;
          end
        end
        FIX: begin
          r_result <= w_fix_res;
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  // Status outputs decoded from state; stall also covers the accepting cycle.
  always_comb begin
    bus.busy   = (r_state != IDLE);
    bus.stall  = ((r_state == IDLE) & w_accept & ~bus.flush) |
                 (r_state == CALC) | (r_state == FIX);
    bus.done   = (r_state == DONE);
    bus.result = r_result;
  end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Iterative radix-2 restoring divider and its control FSM for the RV32IM pipeline's M-extension divide/remainder operations (ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU). It sits beside the EX-stage ALU and accepts one operation at a time. While it runs, it holds the pipeline through the hazard unit's division stall. It returns the result for one cycle so EX can forward it into EX/MEM.

## Interface
- XLEN, 32 (riscv_pkg::XLEN): operand/result width.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- start  in  1  request; honoured only in IDLE with a divide alu_op.
- alu_op  in  alu_op_e (5)  operation; only ALU_DIV..ALU_REMU start the unit.
- operand_a  in  XLEN  dividend (rs1).
- operand_b  in  XLEN  divisor (rs2).
- flush  in  1  kill the in-flight operation (branch mispredict/redirect).
- busy  out  1  state != IDLE.
- stall  out  1  division hazard to the hazard unit.
- done  out  1  one-cycle pulse; result valid.
- result  out  XLEN  quotient or remainder; registered, holds until the next done.

## Operation
- States: IDLE, CALC, FIX, DONE (div_state_e).
- IDLE: start & divide op samples the operands and op; next state is chosen as follows.
  - Divide by zero (operand_b == 0): load the special result, go to DONE. DIV/DIVU give 0xFFFFFFFF; REM/REMU give operand_a.
  - Signed overflow (DIV/REM, a == 0x80000000, b == 0xFFFFFFFF): DIV gives 0x80000000, REM gives 0; go to DONE.
  - Otherwise: latch |a| and |b| (absolute value for signed ops, raw for unsigned; |0x80000000| = 0x80000000 unsigned). Latch neg_q = a[31]^b[31] and neg_r = a[31] (both 0 for unsigned ops). Clear the remainder, load quotient = |a|, counter = XLEN-1, go to CALC.
- CALC, one quotient bit per cycle:
  - Shift {rem, quo} left by 1.
  - trial = rem_shifted - divisor, computed at XLEN+1 bits.
  - If trial >= 0: rem = trial and quo[0] = 1; else quo[0] = 0.
  - At counter == 0, go to FIX; otherwise decrement the counter.
- FIX: result = DIV/DIVU ? (neg_q ? -quo : quo) : (neg_r ? -rem : rem). Go to DONE.
- DONE: done = 1, go to IDLE.
- start outside IDLE, or with a non-divide alu_op, is ignored.
- flush in any state: next state IDLE, no done pulse, result unchanged. flush has priority over start in the same cycle.
- rst_n low: state IDLE, counter 0, internal registers 0.

## Timing
- Reset values: busy 0, stall 0, done 0, result 0.
- stall = (state==IDLE & start & divide op & !flush) | state==CALC | state==FIX.
  - The combinational term in the start cycle lets the ID/EX stage hold the operation immediately.
  - stall is low in DONE so the pipeline advances and captures result.
- Normal operation, start sampled at the edge ending cycle 0:
  - CALC occupies cycles 1..32.
  - FIX occupies cycle 33.
  - DONE (done = 1) in cycle 34: latency 34 cycles.
- Special cases (div by zero, overflow): DONE in cycle 1.
- result updates on the edge entering DONE and is stable for the whole DONE cycle and afterwards.
- Back-to-back: a new start is accepted in the cycle after DONE (IDLE). start during DONE is ignored.
- Reset mid-operation: behaves as flush plus clearing result to 0.

## Structure
- riscv_pkg additions:
  - div_state_e (logic [1:0]: IDLE, CALC, FIX, DONE).
  - DIV_SIGNED_OVF_DIVIDEND = 32'h80000000.
  - DIV_BY_ZERO_QUOTIENT = '1.
- The counter width reuses COUNT_SIZE_DIVISOR.
- hazard_t.division is driven from stall.
- One natural sub-module: div_step, a combinational single restoring iteration taking (rem, quo, divisor) and producing (rem_next, quo_next).

## Test plan
- DIVU 100/7: done in cycle 34 with result 14; REMU 100/7 gives 2; busy high in cycles 1..34.
- DIV -7/2 (0xFFFFFFF9, 2) gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; REM 7/-2 gives 1.
- DIV 5/0 gives 0xFFFFFFFF with done in cycle 1; REMU 5/0 gives 5; DIVU 0/0 gives 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF gives 0x80000000 in cycle 1; REM on the same operands gives 0; DIVU on the same operands gives 0 after 34 cycles.
- Flush in cycle 10 of DIVU 100/7:
  - state is IDLE in cycle 11 and no done pulse is produced.
  - result keeps its previous value.
  - A following DIVU 9/3 gives 3 in 34 cycles.
- start asserted during CALC with other operands is ignored (original result returned); rst_n low in cycle 5 gives result 0 and busy 0 in the next cycle.
